// File: rtl/ot_read.sv
// ---------------------------------------------------------------------------
// ot_read
//   Reads back the output SRAM and streams its contents into a downstream
//   FIFO. A start pulse in IDLE launches ADDR_FINAL reads (addresses
//   0..ADDR_FINAL-1). A 3-entry skid buffer absorbs the 1-cycle SRAM read
//   latency, so the read issue decision never looks at fifo_full_n. The final
//   word is flagged with last_out, and done pulses for one cycle once that
//   word has left the buffer.
//
//   Optional feature macro: OT_READ_STALL_CNT_EN
//     defined   : stall_cnt counts cycles where a word is waiting but the FIFO
//                 is full (saturating), cleared on reset and on an accepted
//                 start.
//     undefined : stall_cnt is tied to zero.
//
// Ports
//   clk             clock
//   reset           synchronous, active-high reset
//   start           1-cycle transfer request, honoured only in IDLE
//   busy            high while reading or draining
//   done            1-cycle pulse after the last word was pushed
//   cen_otsr        SRAM chip enable, active-low
//   wen_otsr        SRAM write enable, active-low (always 1, read-only use)
//   addr_otsr       SRAM read address
//   data_from_sram  SRAM read data, valid the cycle after cen_otsr=0
//   fifo_full_n     downstream FIFO accepts a word this cycle
//   fifo_write      data_out is pushed this cycle
//   data_out        word to the FIFO, zero when fifo_write=0
//   last_out        marks the push of word ADDR_FINAL-1
//   stall_cnt       back-pressure stall counter
// ---------------------------------------------------------------------------
module ot_read #(
  parameter int ADDR_FINAL     = 20,
  parameter int SRAM_DATA_BITS = 64,
  parameter int SRAM_ADDR_BITS = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      cen_otsr,
  output logic                      wen_otsr,
  output logic [SRAM_ADDR_BITS-1:0] addr_otsr,
  input  logic [SRAM_DATA_BITS-1:0] data_from_sram,
  input  logic                      fifo_full_n,
  output logic                      fifo_write,
  output logic [SRAM_DATA_BITS-1:0] data_out,
  output logic                      last_out,
  output logic [15:0]               stall_cnt
);

  // One extra bit so a count of exactly 2**SRAM_ADDR_BITS words fits.
  localparam int                CNT_W    = SRAM_ADDR_BITS + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(ADDR_FINAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]          out_cnt_q, out_cnt_d;
  logic                      rd_pend_q, rd_pend_d;
  logic [1:0]                wr_ptr_q, wr_ptr_d;
  logic [1:0]                rd_ptr_q, rd_ptr_d;
  logic [1:0]                skid_cnt_q, skid_cnt_d;
  logic [SRAM_DATA_BITS-1:0] skid_mem_q [3];

  logic [2:0] occupancy;
  logic       issue;
  logic       push;
  logic       pop;

  // Modulo-3 pointer advance for the skid ring.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read may only be issued when the word it returns is guaranteed a slot:
  // buffered words plus the read still in flight must leave room. This keeps
  // fifo_full_n out of the SRAM enable path entirely.
  always_comb begin
    occupancy = {1'b0, skid_cnt_q} + {2'b00, rd_pend_q};
    issue     = (state_q == S_READ) && (occupancy < 3'd3);
    push      = rd_pend_q;
    pop       = (skid_cnt_q != 2'd0) && fifo_full_n;
  end

  always_comb begin
    rd_pend_d  = issue;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    skid_cnt_d = skid_cnt_q;
    case ({push, pop})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase
  end

  // Next-state and counters. DRAIN looks at the post-cycle buffer count so
  // DONE follows the cycle of the final push directly.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    if (issue) issue_cnt_d = issue_cnt_q + CNT_W'(1);
    if (pop)   out_cnt_d   = out_cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_READ;
          issue_cnt_d = '0;
          out_cnt_d   = '0;
        end
      end
      S_READ: begin
        if (issue && (issue_cnt_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (skid_cnt_d == 2'd0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d     = S_IDLE;
        issue_cnt_d = '0;
        out_cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage boundary: control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      skid_cnt_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      rd_pend_q   <= rd_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      skid_cnt_q  <= skid_cnt_d;
    end
  end

  // Stage boundary: skid data capture. The word returned by last cycle's read
  // is always written; the issue rule guarantees a free slot.
  always_ff @(posedge clk) begin
    if (push) skid_mem_q[wr_ptr_q] <= data_from_sram;
  end

  always_comb begin
    busy       = (state_q == S_READ) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    cen_otsr   = ~issue;
    wen_otsr   = 1'b1;
    addr_otsr  = issue_cnt_q[SRAM_ADDR_BITS-1:0];
    fifo_write = pop;
    data_out   = pop ? skid_mem_q[rd_ptr_q] : '0;
    last_out   = pop && (out_cnt_q == LAST_IDX);
  end

`ifdef OT_READ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = 16'd0;
    end else if ((skid_cnt_q != 2'd0) && !fifo_full_n && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stage boundary: stall counter.
  always_ff @(posedge clk) begin
    if (reset) stall_q <= 16'd0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ot_read.sv
module tb_ot_read;
  localparam int N  = 20;
  localparam int DW = 64;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (ADDR_FINAL = N)
  logic          rst, start, full_n;
  logic          busy, done, cen, wen, fw, last;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata, dout;
  logic [15:0]   stall;

  // Single-word instance (ADDR_FINAL = 1)
  logic          rst1, start1, full1;
  logic          busy1, done1, cen1, wen1, fw1, last1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] rdata1, dout1;
  logic [15:0]   stall1;

  ot_read #(.ADDR_FINAL(N), .SRAM_DATA_BITS(DW), .SRAM_ADDR_BITS(AW)) dut (
    .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done),
    .cen_otsr(cen), .wen_otsr(wen), .addr_otsr(addr), .data_from_sram(rdata),
    .fifo_full_n(full_n), .fifo_write(fw), .data_out(dout), .last_out(last),
    .stall_cnt(stall));

  ot_read #(.ADDR_FINAL(1), .SRAM_DATA_BITS(DW), .SRAM_ADDR_BITS(AW)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .busy(busy1), .done(done1),
    .cen_otsr(cen1), .wen_otsr(wen1), .addr_otsr(addr1), .data_from_sram(rdata1),
    .fifo_full_n(full1), .fifo_write(fw1), .data_out(dout1), .last_out(last1),
    .stall_cnt(stall1));

  function automatic logic [DW-1:0] word(input int a);
    logic [31:0] u;
    u = a;
    return {u ^ 32'h5A5A_0000, u};
  endfunction

  // SRAM models: one cycle read latency
  always @(posedge clk) if (cen == 1'b0) rdata <= word(int'(addr));
  always @(posedge clk) if (cen1 == 1'b0) rdata1 <= word(int'(addr1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: reads issued / words written / words captured, as counts
  bit chk_en = 0;
  bit m_act = 0, m_done = 0;
  int m_iss = 0, m_wr = 0, m_cap = 0, m_stall = 0, since = 0;
  int nwr = 0, ndone = 0, ncen = 0, nlast = 0, first_fw = -1, done_cyc = -1;

  always @(negedge clk) begin : cmp
    bit e_cen0, e_fw;
    int e_addr;
    int e_stall;
    if (chk_en) begin
      e_cen0 = m_act && (m_iss < N) && ((m_iss - m_wr) < 3);
      e_fw   = m_act && ((m_cap - m_wr) > 0) && (full_n == 1'b1);
      e_addr = (m_act || m_done) ? (m_iss % (1 << AW)) : 0;
`ifdef OT_READ_STALL_CNT_EN
      e_stall = m_stall;
`else
      e_stall = 0;
`endif
      chk("busy", 64'(busy), 64'(m_act));
      chk("done", 64'(done), 64'(m_done));
      chk("cen_otsr", 64'(cen), 64'(!e_cen0));
      chk("wen_otsr", 64'(wen), 64'd1);
      chk("addr_otsr", 64'(addr), 64'(e_addr));
      chk("fifo_write", 64'(fw), 64'(e_fw));
      chk("data_out", dout, e_fw ? word(m_wr) : '0);
      chk("last_out", 64'(last), 64'(e_fw && (m_wr == N - 1)));
      chk("stall_cnt", 64'(stall), 64'(e_stall));

      if (fw === 1'b1) begin
        nwr++;
        if (first_fw < 0) first_fw = since;
      end
      if (last === 1'b1) nlast++;
      if (done === 1'b1) begin ndone++; done_cyc = since; end
      if (cen === 1'b0) ncen++;

      if (rst) begin
        m_act = 0; m_done = 0; m_iss = 0; m_wr = 0; m_cap = 0; m_stall = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_act) begin
        if (((m_cap - m_wr) > 0) && (full_n == 1'b0) && (m_stall < 65535)) m_stall++;
        m_cap = m_iss;
        m_iss += int'(e_cen0);
        m_wr  += int'(e_fw);
        if (m_wr == N) begin m_act = 0; m_done = 1; end
      end else if (start) begin
        m_act = 1; m_iss = 0; m_wr = 0; m_cap = 0; m_stall = 0;
        first_fw = -1; since = 0;
      end
      since++;
    end
  end

  // Drive a cycle's inputs, then return just after that cycle's compare.
  task automatic drive(input logic r, input logic s, input logic f);
    @(posedge clk);
    #1;
    rst = r; start = s; full_n = f;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc, input bit toggle);
    int b;
    bit seen;
    b = ndone;
    seen = 0;
    for (int c = 0; c < maxc && !seen; c++) begin
      drive(1'b0, 1'b0, toggle ? logic'(c % 2) : 1'b1);
      if (ndone != b) seen = 1;
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b_wr, b_last, b_cen, b_done, n1, w1_cyc, d1_cyc;
    logic [DW-1:0] w1_data;
    logic w1_last;
    bit fin;

    rst = 1; start = 0; full_n = 1;
    rst1 = 1; start1 = 0; full1 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    rst1 = 0;
    drive(1, 0, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);

    // 1: plain transfer
    b_wr = nwr; b_last = nlast;
    drive(0, 1, 1);
    wait_done(100, 0);
    chk("t1_first_write_cycle", 64'(first_fw), 64'd3);
    chk("t1_done_cycle", 64'(done_cyc), 64'(N + 3));
    chk("t1_words", 64'(nwr - b_wr), 64'(N));
    chk("t1_last_count", 64'(nlast - b_last), 64'd1);
    drive(0, 0, 1);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // 2: toggling back-pressure
    b_wr = nwr;
    drive(0, 1, 1);
    wait_done(200, 1);
    chk("t2_words", 64'(nwr - b_wr), 64'(N));
    drive(0, 0, 1);

    // 3: FIFO full for 10 cycles after start
    b_wr = nwr; b_cen = ncen;
    drive(0, 1, 1);
    repeat (10) drive(0, 0, 0);
    chk("t3_reads_while_full", 64'(ncen - b_cen), 64'd3);
    wait_done(200, 0);
    chk("t3_words", 64'(nwr - b_wr), 64'(N));
`ifndef OT_READ_STALL_CNT_EN
    chk("t3_stall_tied", 64'(stall), 64'd0);
`endif
    drive(0, 0, 1);

    // 4: repeated start while busy
    b_wr = nwr; b_done = ndone;
    drive(0, 1, 1);
    fin = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      drive(0, logic'((c % 3) == 0), 1);
      if (ndone != b_done) fin = 1;
    end
    repeat (5) drive(0, 0, 1);
    chk("t4_done_count", 64'(ndone - b_done), 64'd1);
    chk("t4_words", 64'(nwr - b_wr), 64'(N));

    // 5: reset after the 7th write, then replay
    b_wr = nwr;
    drive(0, 1, 1);
    for (int c = 0; c < 50 && (nwr - b_wr) < 7; c++) drive(0, 0, 1);
    drive(1, 0, 1);
    drive(0, 0, 1);
    chk("t5_busy_after_reset", 64'(busy), 64'd0);
    chk("t5_addr_after_reset", 64'(addr), 64'd0);
    chk("t5_fw_after_reset", 64'(fw), 64'd0);
    b_wr = nwr;
    drive(0, 1, 1);
    wait_done(100, 0);
    chk("t5_replay_words", 64'(nwr - b_wr), 64'(N));
    chk("t5_replay_first_cycle", 64'(first_fw), 64'd3);
    drive(0, 0, 1);

    // Randomized transfers with back-pressure, stray starts and rare resets
    for (int t = 0; t < 8; t++) begin
      int b;
      bit r, s, f;
      b = ndone;
      fin = 0;
      drive(0, 1, logic'($urandom_range(0, 3) != 0));
      for (int c = 0; c < 400 && !fin; c++) begin
        r = ($urandom_range(0, 149) == 0);
        s = ($urandom_range(0, 7) == 0);
        f = (t % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
        drive(r, s, f);
        if (r || (ndone != b)) fin = 1;
      end
      chk("rnd_finished", 64'(fin), 64'd1);
      drive(0, 0, 1);
      drive(0, 0, 1);
    end

    // 6: single-word build
    n1 = 0; w1_cyc = -1; d1_cyc = -1; w1_data = '0; w1_last = 1'b0;
    @(posedge clk); #1; start1 = 1;
    @(posedge clk); #1; start1 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (fw1 === 1'b1) begin n1++; w1_cyc = k; w1_data = dout1; w1_last = last1; end
      if (done1 === 1'b1) d1_cyc = k;
    end
    chk("t6_write_count", 64'(n1), 64'd1);
    chk("t6_write_cycle", 64'(w1_cyc), 64'd3);
    chk("t6_data", w1_data, word(0));
    chk("t6_last", 64'(w1_last), 64'd1);
    chk("t6_done_cycle", 64'(d1_cyc), 64'd4);
    chk("t6_busy_after", 64'(busy1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
